// File: rtl/mult_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mult_arb_pkg
// Purpose  : Shared widths and helpers for the multiplier arbiter/scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package mult_arb_pkg;

    localparam int OPW   = 16;  // operand width
    localparam int PRODW = 32;  // product width

    // Round-robin successor of idx within n slots
    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mult_arb_sched_if.sv
`default_nettype none
// ============================================================================
// Module   : mult_arb_sched_if
// Purpose  : Requester-side request/response bundle of mult_arb_sched.
//            master = requesters, slave = scheduler.
// Revision : 1.0 - initial release
// ============================================================================
interface mult_arb_sched_if
    import mult_arb_pkg::*;
#(
    parameter int NUM_REQ = 4
) ();

    logic [NUM_REQ-1:0]     req_valid;
    logic [NUM_REQ*OPW-1:0] req_a;
    logic [NUM_REQ*OPW-1:0] req_b;
    logic [NUM_REQ-1:0]     req_ready;
    logic [NUM_REQ-1:0]     rsp_valid;
    logic [PRODW-1:0]       rsp_data;

    modport master (
        output req_valid, req_a, req_b,
        input  req_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_a, req_b,
        output req_ready, rsp_valid, rsp_data
    );

endinterface
`default_nettype wire

// File: rtl/mult_arb_sched_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Purpose  : Combinational one-hot round-robin grant with a registered
//            pointer that moves past the winner when the grant is accepted.
//            Macro MULT_ARB_PRIO0_EN: request 0 wins whenever asserted and
//            its grants leave the pointer untouched.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import mult_arb_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  wire                  clk,
    input  wire                  rst,
    input  wire  [NUM_REQ-1:0]   req,
    input  wire                  accept,
    output logic [NUM_REQ-1:0]   grant,
    output logic [$clog2(NUM_REQ)-1:0] grant_idx
);

    localparam int IDW = $clog2(NUM_REQ);

    logic [IDW-1:0] r_ptr;
    logic           w_found;
    logic           w_move;
    int             w_pos;

    // First requesting index at or after the pointer, wrapping around
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        w_found   = 1'b0;
        w_pos     = 0;
`ifdef MULT_ARB_PRIO0_EN
        if (req[0]) begin
            grant[0] = 1'b1;
            w_found  = 1'b1;
        end
`endif
        for (int k = 0; k < NUM_REQ; k++) begin
            w_pos = (int'(r_ptr) + k) % NUM_REQ;
            if (!w_found && req[w_pos]) begin
                w_found       = 1'b1;
                grant[w_pos]  = 1'b1;
                grant_idx     = IDW'(w_pos);
            end
        end
    end

`ifdef MULT_ARB_PRIO0_EN
    assign w_move = accept && w_found && (grant_idx != '0);
`else
    assign w_move = accept && w_found;
`endif

    // Pointer advances past the accepted winner, otherwise holds
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (w_move) begin
            r_ptr <= IDW'(rr_next(int'(grant_idx), NUM_REQ));
        end
    end

endmodule
`default_nettype wire

// File: rtl/mult_arb_sched.sv
`default_nettype none
// ============================================================================
// Module   : mult_arb_sched
// Purpose  : Shares one fixed-latency pipelined multiplier among NUM_REQ
//            requesters. Grants one operand pair per cycle, tags it with the
//            requester id and returns the product as a one-cycle pulse.
//            Optional macro MULT_ARB_PRIO0_EN: requester 0 strict priority.
// Revision : 1.0 - initial release
// ============================================================================
module mult_arb_sched
    import mult_arb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int MULT_LAT  = 8,
    parameter int MAX_OUTST = 3
) (
    input  wire              clk,
    input  wire              rst,
    mult_arb_sched_if.slave  bus,
    input  wire              drain,
    output logic             mul_en,
    output logic [OPW-1:0]   mul_a,
    output logic [OPW-1:0]   mul_b,
    input  wire  [PRODW-1:0] mul_p,
    output logic             busy
);

    localparam int IDW  = $clog2(NUM_REQ);
    localparam int CNTW = 4;
    localparam logic [CNTW-1:0] c_MAX_OUTST = CNTW'(MAX_OUTST);

    // In-flight tag; id width follows NUM_REQ
    typedef struct packed {
        logic           v;
        logic [IDW-1:0] id;
    } tag_t;

    logic [NUM_REQ-1:0] w_elig;
    logic [NUM_REQ-1:0] w_grant;
    logic [NUM_REQ-1:0] w_dec;
    logic [IDW-1:0]     w_gidx;
    logic               w_hs;
    logic               w_any;
    tag_t               w_tail;
    tag_t               r_tag [MULT_LAT+1];
    logic [CNTW-1:0]    r_cnt [NUM_REQ];
    logic [CNTW-1:0]    w_cnt_nxt [NUM_REQ];
    logic [NUM_REQ-1:0] r_rsp_valid;
    logic [PRODW-1:0]   r_rsp_data;

    // A requester competes only with room for another in-flight op
    always_comb begin
        w_elig = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_elig[i] = bus.req_valid[i] && (r_cnt[i] < c_MAX_OUTST) && !drain && !rst;
        end
    end

    rr_arbiter #(
        .NUM_REQ   (NUM_REQ)
    ) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (w_elig),
        .accept    (w_hs),
        .grant     (w_grant),
        .grant_idx (w_gidx)
    );

    assign w_hs          = |w_grant;
    assign bus.req_ready = w_grant;

    // Register the granted operand pair towards the multiplier
    always_ff @(posedge clk) begin
        if (rst) begin
            mul_en <= 1'b0;
            mul_a  <= '0;
            mul_b  <= '0;
        end else begin
            mul_en <= w_hs;
            if (w_hs) begin
                mul_a <= bus.req_a[int'(w_gidx)*OPW +: OPW];
                mul_b <= bus.req_b[int'(w_gidx)*OPW +: OPW];
            end
        end
    end

    // Tag pipe: stage 0 rides with mul_en, last stage lines up with mul_p
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s <= MULT_LAT; s++) begin
                r_tag[s] <= '0;
            end
        end else begin
            r_tag[0] <= '{v: w_hs, id: w_gidx};
            for (int s = 1; s <= MULT_LAT; s++) begin
                r_tag[s] <= r_tag[s-1];
            end
        end
    end

    assign w_tail = r_tag[MULT_LAT];

    // Decode the completing tag into a per-requester pulse
    always_comb begin
        w_dec = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_dec[i] = w_tail.v && (w_tail.id == IDW'(i));
        end
    end

    // Response pulse and captured product; data holds between pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_valid <= '0;
            r_rsp_data  <= '0;
        end else begin
            r_rsp_valid <= w_dec;
            if (w_tail.v) begin
                r_rsp_data <= mul_p;
            end
        end
    end

    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_data  = r_rsp_data;

    // Next outstanding counts; the decrement lands with the response pulse
    always_comb begin
        w_any = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_cnt_nxt[i] = r_cnt[i] + CNTW'(w_grant[i]) - CNTW'(w_dec[i]);
            w_any        = w_any | (w_cnt_nxt[i] != '0);
        end
    end

    // Outstanding counters and busy flag
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                r_cnt[i] <= '0;
            end
            busy <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                r_cnt[i] <= w_cnt_nxt[i];
            end
            busy <= w_any;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mult_arb_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_mult_arb_sched
// Purpose  : Self-checking bench for mult_arb_sched with a behavioural
//            pipelined multiplier and a response scoreboard.
//            Macro MULT_ARB_PRIO0_EN selects the strict-priority scenario.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mult_arb_sched;
    import mult_arb_pkg::*;

    localparam int NUM_REQ  = 4;
    localparam int MULT_LAT = 8;
`ifdef MULT_ARB_PRIO0_EN
    localparam int MAX_OUTST = 15;
`else
    localparam int MAX_OUTST = 3;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              drain = 1'b0;
    logic              mul_en;
    logic [OPW-1:0]    mul_a;
    logic [OPW-1:0]    mul_b;
    logic [PRODW-1:0]  mul_p;
    logic              busy;

    mult_arb_sched_if #(.NUM_REQ(NUM_REQ)) bus ();

    mult_arb_sched #(
        .NUM_REQ   (NUM_REQ),
        .MULT_LAT  (MULT_LAT),
        .MAX_OUTST (MAX_OUTST)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus),
        .drain  (drain),
        .mul_en (mul_en),
        .mul_a  (mul_a),
        .mul_b  (mul_b),
        .mul_p  (mul_p),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    // Behavioural multiplier: product valid MULT_LAT cycles after mul_en
    logic [PRODW-1:0] mpipe [MULT_LAT];
    always @(posedge clk) begin
        mpipe[0] <= mul_en ? (32'(mul_a) * 32'(mul_b)) : 32'hDEADBEEF;
        for (int s = 1; s < MULT_LAT; s++) begin
            mpipe[s] <= mpipe[s-1];
        end
    end
    assign mul_p = mpipe[MULT_LAT-1];

    typedef struct {
        logic [NUM_REQ-1:0] who;
        logic [PRODW-1:0]   prod;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;
    int   n_rsp    = 0;
    int   last_g   = -1;
    bit   last_hs  = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: sample handshakes/responses mid-cycle, end at posedge+1
    task automatic tick();
        exp_t e;
        e.who  = '0;
        e.prod = '0;
        @(negedge clk);
        last_hs = 1'b0;
        last_g  = -1;
        if ((bus.req_valid & bus.req_ready) != '0) begin
            last_hs = 1'b1;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (bus.req_ready[i]) begin
                    last_g = i;
                    e.who  = NUM_REQ'(1 << i);
                    e.prod = 32'(bus.req_a[16*i +: 16]) * 32'(bus.req_b[16*i +: 16]);
                end
            end
            sb.push_back(e);
        end
        if (bus.req_ready != '0) begin
            chk("grant_legal", 32'($onehot(bus.req_ready) && ((bus.req_ready & ~bus.req_valid) == '0)), 32'd1);
        end
        if (bus.rsp_valid != '0) begin
            n_rsp++;
            if (sb.size() == 0) begin
                chk("rsp_unexpected", 32'(bus.rsp_valid), 32'd0);
            end else begin
                e = sb.pop_front();
                chk("rsp_who", 32'(bus.rsp_valid), 32'(e.who));
                chk("rsp_data", bus.rsp_data, e.prod);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input string t);
        chk({t, "_req_ready"}, 32'(bus.req_ready), 32'd0);
        chk({t, "_mul_en"},    32'(mul_en),        32'd0);
        chk({t, "_mul_a"},     32'(mul_a),         32'd0);
        chk({t, "_mul_b"},     32'(mul_b),         32'd0);
        chk({t, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
        chk({t, "_rsp_data"},  bus.rsp_data,       32'd0);
        chk({t, "_busy"},      32'(busy),          32'd0);
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        bus.req_valid = '0;
        drain         = 1'b0;
        @(posedge clk);
        #1;
        chk_reset("rst");
        rst = 1'b0;
        sb.delete();
    endtask

    task automatic wait_idle(input string t);
        bit idle;
        idle = 1'b0;
        for (int c = 0; c < 40 && !idle; c++) begin
            tick();
            idle = (sb.size() == 0) && (busy == 1'b0);
        end
        chk({t, "_idle"}, 32'(idle), 32'd1);
    endtask

    task automatic rand_ops();
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.req_a[16*i +: 16] = 16'($urandom);
            bus.req_b[16*i +: 16] = 16'($urandom);
        end
    endtask

    initial begin
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        do_reset();

        // 1: single op from requester 1
        bus.req_valid     = 4'b0010;
        bus.req_a[31:16]  = 16'h0003;
        bus.req_b[31:16]  = 16'h0005;
        tick();
        bus.req_valid = '0;
        chk("t1_mul_en", 32'(mul_en), 32'd1);
        chk("t1_mul_a",  32'(mul_a),  32'h3);
        chk("t1_mul_b",  32'(mul_b),  32'h5);
        chk("t1_busy_hi", 32'(busy),  32'd1);
        repeat (8) tick();
        chk("t1_no_early_rsp", 32'(bus.rsp_valid), 32'd0);
        tick();
        chk("t1_rsp_valid", 32'(bus.rsp_valid), 32'b0010);
        chk("t1_rsp_data",  bus.rsp_data,       32'h0000000F);
        tick();
        chk("t1_busy_lo",   32'(busy),          32'd0);
        chk("t1_rsp_once",  32'(bus.rsp_valid), 32'd0);
        chk("t1_data_hold", bus.rsp_data,       32'h0000000F);

`ifndef MULT_ARB_PRIO0_EN
        // 2: all requesters continuously valid, round-robin order
        do_reset();
        bus.req_valid = 4'hF;
        for (int k = 0; k < 12; k++) begin
            rand_ops();
            if (k == 0) begin
                bus.req_a[15:0] = 16'hFFFF;
                bus.req_b[15:0] = 16'hFFFF;
            end
            tick();
            chk("t2_grant", 32'(last_g), 32'(k % NUM_REQ));
        end
        bus.req_valid = '0;
        wait_idle("t2");

        // 3: outstanding limit on requester 2
        do_reset();
        rand_ops();
        bus.req_valid = 4'b0100;
        for (int c = 0; c < 14; c++) begin
            tick();
            chk("t3_grant", 32'(last_hs), 32'((c < 3) || (c >= 10 && c <= 12)));
        end
        bus.req_valid = '0;
        wait_idle("t3");
`endif

        // 4: drain with 5 ops in flight
        do_reset();
        rand_ops();
        bus.req_valid = 4'hF;
        repeat (5) tick();
        drain = 1'b1;
        begin
            int n0;
            n0 = n_rsp;
            chk("t4_busy_start", 32'(busy), 32'd1);
            for (int c = 0; c < 14; c++) begin
                #1;
                chk("t4_ready_drain", 32'(bus.req_ready), 32'd0);
                if (c == 8) chk("t4_busy_inflight", 32'(busy), 32'd1);
                tick();
            end
            chk("t4_rsp_count", 32'(n_rsp - n0), 32'd5);
            chk("t4_busy_end", 32'(busy), 32'd0);
        end
        drain = 1'b0;
        tick();
`ifdef MULT_ARB_PRIO0_EN
        chk("t4_resume", 32'(last_g), 32'd0);
`else
        chk("t4_resume", 32'(last_g), 32'd1);
`endif
        bus.req_valid = '0;
        wait_idle("t4");

        // 5: reset while 3 ops are in flight
        do_reset();
        rand_ops();
        bus.req_valid = 4'b0111;
        repeat (3) tick();
        bus.req_valid = '0;
        repeat (4) tick();
        rst           = 1'b1;
        bus.req_valid = 4'b1001;
        #1;
        chk("t5_ready_in_rst", 32'(bus.req_ready), 32'd0);
        @(posedge clk);
        #1;
        chk_reset("t5");
        rst           = 1'b0;
        bus.req_valid = '0;
        sb.delete();
        for (int c = 0; c < 12; c++) begin
            tick();
            chk("t5_no_rsp", 32'(bus.rsp_valid), 32'd0);
        end
        bus.req_valid = 4'b1001;
        #1;
        chk("t5_first_grant", 32'(bus.req_ready), 32'b0001);
        tick();
        bus.req_valid = '0;
        wait_idle("t5");

`ifdef MULT_ARB_PRIO0_EN
        // 6: requester 0 strict priority over requester 3
        do_reset();
        rand_ops();
        bus.req_valid = 4'b1001;
        for (int c = 0; c < 6; c++) begin
            tick();
            chk("t6_prio0", 32'(last_g), 32'd0);
        end
        bus.req_valid = 4'b1000;
        tick();
        chk("t6_req3", 32'(last_g), 32'd3);
        bus.req_valid = '0;
        wait_idle("t6");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/mult_arb_sched.md
Name: mult_arb_sched

Overview:
- Round-robin arbiter and scheduler that shares one fixed-latency pipelined 16x16 unsigned multiplier among NUM_REQ requesters.
- Accepts at most one operand pair per cycle and drives it into the multiplier.
- Tracks each in-flight operation with a requester-ID tag pipeline, and routes each product back to its originator as a one-cycle response pulse.
- Sits between the memory-block producers and the multiplier datapath, replacing point-to-point multiplier hookup.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- MULT_LAT, 8, multiplier latency in cycles from mul_en to valid mul_p (>=1)
- MAX_OUTST, 3, max in-flight operations per requester (1..15)
- IDW, $clog2(NUM_REQ), tag width (derived, not overridable)

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- req_valid  in  NUM_REQ  per-requester operand valid
- req_a  in  NUM_REQ*16  packed operand A; requester i occupies [16*i+:16]
- req_b  in  NUM_REQ*16  packed operand B, same packing
- req_ready  out  NUM_REQ  one-hot grant; handshake when req_valid[i]&req_ready[i]
- drain  in  1  level; stop issuing new grants
- mul_en  out  1  operand valid to multiplier
- mul_a  out  16  operand A to multiplier
- mul_b  out  16  operand B to multiplier
- mul_p  in  32  product from multiplier, valid MULT_LAT cycles after mul_en
- rsp_valid  out  NUM_REQ  one-hot response pulse
- rsp_data  out  32  product for the pulsing requester
- busy  out  1  high while any operation is in flight

Behaviour:
- Reset values:
  - req_ready=0, mul_en=0, mul_a=0, mul_b=0, rsp_valid=0, rsp_data=0, busy=0.
  - RR pointer=0, all outstanding counters=0, tag pipe cleared.
- Eligibility: requester i is eligible when req_valid[i]=1, cnt[i]<MAX_OUTST, drain=0, rst=0.
- Grant:
  - Combinational one-hot req_ready[i] for the first eligible index at or after ptr, wrapping modulo NUM_REQ.
  - req_ready never asserts for an ineligible requester.
  - At most one bit is set.
- Pointer: after a handshake on index g, ptr <= (g+1) mod NUM_REQ. With no handshake, ptr holds.
- Issue (handshake at cycle T):
  - mul_en=1, mul_a=req_a[g], mul_b=req_b[g] registered at T+1.
  - mul_en=0 on cycles without a handshake; mul_a/mul_b hold their last values.
- Tag pipe:
  - MULT_LAT+1 stage shift register of {valid, id}.
  - Entry is launched alongside mul_en; stage MULT_LAT aligns with valid mul_p at T+1+MULT_LAT.
- Response:
  - Registered at T+2+MULT_LAT: rsp_valid[id]=1 for exactly one cycle; rsp_data = mul_p sampled at T+1+MULT_LAT.
  - rsp_data holds between pulses.
  - No response back-pressure; requesters must sink every pulse.
  - Total handshake-to-response latency is MULT_LAT+2.
- Ordering: responses leave in issue order. Back-to-back issue gives back-to-back responses, throughput 1/cycle.
- Outstanding counters (4-bit each):
  - +1 on handshake, -1 on rsp_valid pulse; simultaneous +1/-1 leaves the count unchanged.
  - Never exceeds MAX_OUTST; never underflows.
- busy = any counter nonzero (registered, from next-state counts).
- drain:
  - Takes effect the same cycle it is asserted.
  - In-flight operations complete normally.
  - Deasserting drain resumes arbitration from the current ptr.
- Reset mid-operation: tag pipe is flushed and in-flight results are dropped. No rsp_valid may appear after rst, even though mul_p may still carry stale data.
- Arithmetic: unsigned; full 32-bit product passed through unmodified.

Optional Feature:
- Macro: MULT_ARB_PRIO0_EN.
- Defined: requester 0 has strict priority. Whenever it is eligible it is granted, regardless of ptr, and ptr is not updated on its grants. Requesters 1..NUM_REQ-1 round-robin among themselves when requester 0 is not eligible.
- Undefined: pure round-robin across all requesters as above.

Decomposition:
- Shared package mult_arb_pkg holds:
  - localparam OPW=16, PRODW=32
  - typedef struct packed {logic v; logic [IDW-1:0] id;} tag_t, made generic via a width parameter in the module
- Natural sub-module: rr_arbiter (NUM_REQ-wide request vector in, one-hot grant out, pointer update on accept). It is reused later for memory-port sharing.

Test Plan:
1. Reset, then requester 1 sends a=16'h0003, b=16'h0005 at T → mul_en at T+1; rsp_valid=4'b0010, rsp_data=32'h0000000F at T+10 (MULT_LAT=8); busy low at T+11.
2. All 4 requesters valid continuously with distinct operands, ptr=0 → grants 0,1,2,3,0,... one per cycle; responses in the same order with correct products (e.g. 16'hFFFF*16'hFFFF=32'hFFFE0001).
3. Requester 2 alone, valid every cycle, MAX_OUTST=3 → 3 grants, then req_ready[2]=0 until its first response. A new grant occurs the cycle of the response pulse, and the count stays 3.
4. drain raised with 5 operations in flight → no req_ready while drain=1; all 5 responses still arrive; busy falls after the last response.
5. rst pulsed 4 cycles after 3 issues → outputs at reset values; no rsp_valid in the following 12 cycles; first post-reset grant goes to requester 0.
6. MULT_ARB_PRIO0_EN defined, requesters 0 and 3 valid continuously with MAX_OUTST=15 → requester 0 granted every cycle and requester 3 starved; drop req_valid[0] → requester 3 granted the next cycle.
